// File: rtl/saper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | saper_pkg : shared types and constants for the mine placer         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package saper_pkg;

  localparam int          MAX_DIM           = 8;
  localparam int          COORD_W           = $clog2(MAX_DIM);
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } placer_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mine_placer_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mine_placer_ctrl_if : game-FSM side settings and board write port  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mine_placer_ctrl_if;
  import saper_pkg::*;

  logic               start;
  logic [4:0]         dimension_size;
  logic [5:0]         mines;
  logic [COORD_W-1:0] safe_x;
  logic [COORD_W-1:0] safe_y;
  logic               wr_en;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic               wr_data;
  logic               busy;
  logic               done;
  logic               board_valid;
  logic [5:0]         mines_placed;

  modport master (
    output start, dimension_size, mines, safe_x, safe_y,
    input  wr_en, wr_x, wr_y, wr_data, busy, done, board_valid, mines_placed
  );

  modport slave (
    input  start, dimension_size, mines, safe_x, safe_y,
    output wr_en, wr_x, wr_y, wr_data, busy, done, board_valid, mines_placed
  );
endinterface
`default_nettype wire

// File: rtl/mine_placer_ctrl_lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lfsr16 : free-running 16-bit Fibonacci LFSR, seed loaded on reset  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lfsr16
  import saper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] out
);
  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= seed;
    else      r_state <= lfsr_next(r_state);
  end

  assign out = r_state;
endmodule
`default_nettype wire

// File: rtl/mine_placer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mine_placer_ctrl : clears the board, then places non-duplicate     |
// | pseudo-random mines avoiding the safe cell.  rev 1.0               |
// +--------------------------------------------------------------------+
module mine_placer_ctrl
  import saper_pkg::*;
#(
  parameter int          MAX_DIM   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  mine_placer_ctrl_if.slave  bus
);
  localparam logic [3:0] C_DIM_MAX = 4'(MAX_DIM);

  placer_state_e      r_state;
  logic [3:0]         r_dim;
  logic [5:0]         r_mines;
  logic [COORD_W-1:0] r_safe_x, r_safe_y, r_cx, r_cy;
  logic               r_safe_en;
  logic [63:0]        r_bitmap;
  logic               r_wr_en, r_wr_data, r_busy, r_done, r_board_valid;
  logic [COORD_W-1:0] r_wr_x, r_wr_y;
  logic [5:0]         r_mines_placed;

  logic [15:0]        w_lfsr;
  logic [9:0]         w_unused_lfsr;
  logic [3:0]         w_dim;
  logic [6:0]         w_cells, w_mines_max;
  logic [5:0]         w_mines;
  logic               w_safe_en, w_accept, w_x_last, w_y_last;
  logic [COORD_W-1:0] w_cand_x, w_cand_y;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .out(w_lfsr));

  assign w_unused_lfsr = w_lfsr[15:6];
  assign w_cand_x      = w_lfsr[2:0];
  assign w_cand_y      = w_lfsr[5:3];

  // Settings clamp, evaluated against the live inputs and latched on start
  always_comb begin
    w_dim = bus.dimension_size[3:0];
    if (bus.dimension_size > 5'(C_DIM_MAX)) w_dim = C_DIM_MAX;
    else if (bus.dimension_size < 5'd2)     w_dim = 4'd2;
    w_cells     = 7'(w_dim) * 7'(w_dim);
    w_mines_max = w_cells - 7'd1;
    w_mines     = ({1'b0, bus.mines} > w_mines_max) ? w_mines_max[5:0] : bus.mines;
    w_safe_en   = ({1'b0, bus.safe_x} < w_dim) && ({1'b0, bus.safe_y} < w_dim);
  end

  assign w_accept = ({1'b0, w_cand_x} < r_dim) && ({1'b0, w_cand_y} < r_dim)
                  && !r_bitmap[{w_cand_y, w_cand_x}]
                  && !(r_safe_en && (w_cand_x == r_safe_x) && (w_cand_y == r_safe_y));
  assign w_x_last = ({1'b0, r_cx} == (r_dim - 4'd1));
  assign w_y_last = ({1'b0, r_cy} == (r_dim - 4'd1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_dim          <= 4'd0;
      r_mines        <= 6'd0;
      r_safe_x       <= '0;
      r_safe_y       <= '0;
      r_safe_en      <= 1'b0;
      r_cx           <= '0;
      r_cy           <= '0;
      r_bitmap       <= 64'd0;
      r_wr_en        <= 1'b0;
      r_wr_x         <= '0;
      r_wr_y         <= '0;
      r_wr_data      <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_board_valid  <= 1'b0;
      r_mines_placed <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_wr_en       <= 1'b0;
          r_wr_data     <= 1'b0;
          r_busy        <= 1'b0;
          // board_valid is still low on the first DONE cycle, giving a one-shot pulse
          r_board_valid <= (r_state == ST_DONE);
          r_done        <= (r_state == ST_DONE) && !r_board_valid;
          if (bus.start) begin
            r_dim          <= w_dim;
            r_mines        <= w_mines;
            r_safe_x       <= bus.safe_x;
            r_safe_y       <= bus.safe_y;
            r_safe_en      <= w_safe_en;
            r_cx           <= '0;
            r_cy           <= '0;
            r_bitmap       <= 64'd0;
            r_mines_placed <= 6'd0;
            r_state        <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_busy        <= 1'b1;
          r_done        <= 1'b0;
          r_board_valid <= 1'b0;
          r_wr_en       <= 1'b1;
          r_wr_data     <= 1'b0;
          r_wr_x        <= r_cx;
          r_wr_y        <= r_cy;
          if (w_x_last) begin
            r_cx <= '0;
            if (w_y_last) r_state <= (r_mines != 6'd0) ? ST_PLACE : ST_DONE;
            else          r_cy    <= r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        ST_PLACE: begin
          r_busy    <= 1'b1;
          r_wr_en   <= w_accept;
          r_wr_data <= w_accept;
          if (w_accept) begin
            r_wr_x                       <= w_cand_x;
            r_wr_y                       <= w_cand_y;
            r_bitmap[{w_cand_y, w_cand_x}] <= 1'b1;
            r_mines_placed               <= r_mines_placed + 6'd1;
            if ((r_mines_placed + 6'd1) == r_mines) r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_x         = r_wr_x;
  assign bus.wr_y         = r_wr_y;
  assign bus.wr_data      = r_wr_data;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.board_valid  = r_board_valid;
  assign bus.mines_placed = r_mines_placed;
endmodule
`default_nettype wire

// File: tb/tb_mine_placer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mine_placer_ctrl : directed + randomized rounds vs trace model  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mine_placer_ctrl;
  import saper_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mine_placer_ctrl_if bus();

  mine_placer_ctrl #(.MAX_DIM(8), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr;
  logic [15:0] lfsr_before;

  typedef struct {
    bit en; int x; int y; bit data; bit busy; bit done; bit bv; int mp;
  } exp_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic exp_t mk(bit en, int x, int y, bit data, bit busy, bit done, bit bv, int mp);
    exp_t e;
    e.en = en; e.x = x; e.y = y; e.data = data;
    e.busy = busy; e.done = done; e.bv = bv; e.mp = mp;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; the model LFSR tracks reset-load and per-cycle advance
  task automatic tick();
    lfsr_before = m_lfsr;
    @(posedge clk);
    m_lfsr = rst ? lfsr_step(m_lfsr) : SEED;
    @(negedge clk);
  endtask

  task automatic drive_noise();
    bus.dimension_size = 5'($urandom_range(0, 31));
    bus.mines          = 6'($urandom_range(0, 63));
    bus.safe_x         = 3'($urandom_range(0, 7));
    bus.safe_y         = 3'($urandom_range(0, 7));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wr_en"},        bus.wr_en,        0);
    check({tag, ".wr_x"},         bus.wr_x,         0);
    check({tag, ".wr_y"},         bus.wr_y,         0);
    check({tag, ".wr_data"},      bus.wr_data,      0);
    check({tag, ".busy"},         bus.busy,         0);
    check({tag, ".done"},         bus.done,         0);
    check({tag, ".board_valid"},  bus.board_valid,  0);
    check({tag, ".mines_placed"}, bus.mines_placed, 0);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) tick();
  endtask

  // Runs one round; poke pulses start mid-PLACE, abort_at>=0 asserts reset at that trace index
  task automatic run_round(input string tag, input int d_in, input int m_in,
                           input int sx, input int sy, input bit poke, input int abort_at);
    int d, m, placed, done_idx, poke_idx, nmines;
    bit sen;
    bit used[64];
    bit board[64];
    exp_t q[$];
    exp_t e;
    logic [15:0] lf;

    d   = (d_in < 2) ? 2 : ((d_in > 8) ? 8 : d_in);
    m   = (m_in > d * d - 1) ? d * d - 1 : m_in;
    sen = (sx < d) && (sy < d);

    bus.start          = 1'b1;
    bus.dimension_size = 5'(d_in);
    bus.mines          = 6'(m_in);
    bus.safe_x         = 3'(sx);
    bus.safe_y         = 3'(sy);
    tick();
    lf = lfsr_before;

    for (int y = 0; y < d; y++)
      for (int x = 0; x < d; x++) begin
        q.push_back(mk(1, x, y, 0, 1, 0, 0, 0));
        lf = lfsr_step(lf);
      end
    placed = 0;
    for (int k = 0; k < 20000 && placed < m; k++) begin
      int cx, cy;
      lf = lfsr_step(lf);
      cx = int'(lf[2:0]);
      cy = int'(lf[5:3]);
      if (cx < d && cy < d && !used[cy * 8 + cx] && !(sen && cx == sx && cy == sy)) begin
        used[cy * 8 + cx] = 1'b1;
        placed++;
        q.push_back(mk(1, cx, cy, 1, 1, 0, 0, placed));
      end else begin
        q.push_back(mk(0, 0, 0, 0, 1, 0, 0, placed));
      end
    end
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, m));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, m));
    done_idx = q.size() - 2;
    poke_idx = (poke && done_idx > d * d) ? d * d + (done_idx - d * d) / 2 : -1;

    foreach (q[i]) begin
      drive_noise();
      bus.start = (i == poke_idx);
      if (i == abort_at) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.start = 1'b0;
        check_reset_vals({tag, ".abort"});
        return;
      end
      tick();
      e = q[i];
      check($sformatf("%s[%0d].wr_en", tag, i),        bus.wr_en,        e.en);
      check($sformatf("%s[%0d].busy", tag, i),         bus.busy,         e.busy);
      check($sformatf("%s[%0d].done", tag, i),         bus.done,         e.done);
      check($sformatf("%s[%0d].board_valid", tag, i),  bus.board_valid,  e.bv);
      check($sformatf("%s[%0d].mines_placed", tag, i), bus.mines_placed, e.mp);
      if (e.en) begin
        check($sformatf("%s[%0d].wr_x", tag, i),    bus.wr_x,    e.x);
        check($sformatf("%s[%0d].wr_y", tag, i),    bus.wr_y,    e.y);
        check($sformatf("%s[%0d].wr_data", tag, i), bus.wr_data, e.data);
      end
      if (bus.wr_en === 1'b1) board[int'(bus.wr_y) * 8 + int'(bus.wr_x)] = bus.wr_data;
    end
    bus.start = 1'b0;

    nmines = 0;
    for (int c = 0; c < 64; c++) if (board[c]) nmines++;
    check({tag, ".board_mines"}, nmines, m);
    if (sen) check({tag, ".safe_clear"}, board[sy * 8 + sx], 0);
  endtask

  initial begin
    bus.start = 1'b0;
    drive_noise();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b1;
    idle(2);

    run_round("d5m6",   5,  6, 2, 2, 0, -1);
    idle(3);
    run_round("d8m63",  8, 63, 0, 0, 0, -1);
    idle(1);
    run_round("d12m60", 12, 60, 3, 4, 0, -1);
    run_round("d2m10",  2, 10, 1, 0, 0, -1);
    idle(5);
    run_round("d4m0",   4,  0, 1, 1, 0, -1);
    run_round("poke",   6, 10, 5, 5, 1, -1);
    idle(2);
    run_round("abort",  6,  8, 0, 1, 0, 13);
    idle(2);
    run_round("after",  7, 12, 6, 3, 0, -1);
    run_round("nosafe", 3,  9, 5, 1, 0, -1);

    for (int r = 0; r < 6; r++) begin
      idle($urandom_range(0, 7));
      run_round($sformatf("rnd%0d", r), $urandom_range(0, 31), $urandom_range(0, 63),
                $urandom_range(0, 7), $urandom_range(0, 7), r[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
